// File: rtl/fetch_unit_if.sv
// Bundle of instruction-memory, redirect and IF/ID signals shared by fetch_unit and its environment.
// A transfer happens on a rising clk edge when valid and ready are both high; valid never waits on ready.
interface fetch_unit_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;

   modport master (
      output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
      input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect, redirect_pc, if_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
      output imem_req_ready, imem_resp_valid, imem_resp_data, redirect, redirect_pc, if_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// In-order instruction fetch with credit-limited requests, tag queue and DEPTH-entry output FIFO.
// Optional macro FETCH_BYPASS_EN forwards a response straight to if_* when the FIFO is empty.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input logic          clk,
   input logic          reset,
   fetch_unit_if.master bus
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   typedef logic [PW-1:0] ptr_t;
   typedef logic [CW-1:0] cnt_t;
   localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
   localparam ptr_t LAST_P  = ptr_t'(DEPTH - 1);

   logic [31:0] pc;
   cnt_t        outstanding;
   cnt_t        drop_cnt;
   cnt_t        count;
   ptr_t        rd_ptr, wr_ptr, tag_rd, tag_wr;
   logic [31:0] data_mem [DEPTH];
   logic [31:0] pc_mem   [DEPTH];
   logic [31:0] tag_mem  [DEPTH];

   logic        req_fire, resp_arrive, resp_keep, push, pop, fifo_empty;
   logic [CW:0] inflight;

   function automatic ptr_t next_ptr(input ptr_t p);
      return (p == LAST_P) ? '0 : ptr_t'(p + ptr_t'(1));
   endfunction

   // Outstanding plus buffered never exceeds DEPTH, so every response has a FIFO slot.
   assign inflight           = {1'b0, outstanding} + {1'b0, count};
   assign bus.imem_req_valid = !reset && !bus.redirect && (inflight < {1'b0, DEPTH_C});
   assign bus.imem_req_addr  = pc;
   assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;
   assign resp_arrive        = bus.imem_resp_valid && (outstanding != '0);
   assign resp_keep          = resp_arrive && !bus.redirect && (drop_cnt == '0);
   assign fifo_empty         = (count == '0);
   assign pop                = !fifo_empty && bus.if_ready && !bus.redirect;

`ifdef FETCH_BYPASS_EN
   logic bypass;
   assign bypass       = resp_keep && fifo_empty;
   assign bus.if_valid = !fifo_empty || bypass;
   assign bus.if_instr = fifo_empty ? bus.imem_resp_data : data_mem[rd_ptr];
   assign bus.if_pc    = fifo_empty ? tag_mem[tag_rd] : pc_mem[rd_ptr];
   assign push         = resp_keep && !(bypass && bus.if_ready);
`else
   assign bus.if_valid = !fifo_empty;
   assign bus.if_instr = data_mem[rd_ptr];
   assign bus.if_pc    = pc_mem[rd_ptr];
   assign push         = resp_keep;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc          <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
         count       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         tag_rd      <= '0;
         tag_wr      <= '0;
      end else begin
         outstanding <= outstanding + cnt_t'(req_fire) - cnt_t'(resp_arrive);
         if (bus.redirect) begin
            // Everything still in flight belongs to the wrong path and must be dropped on arrival.
            pc       <= bus.redirect_pc & 32'hFFFF_FFFC;
            drop_cnt <= outstanding - cnt_t'(resp_arrive);
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            tag_rd   <= '0;
            tag_wr   <= '0;
         end else begin
            if (req_fire) begin
               pc     <= pc + 32'd4;
               tag_wr <= next_ptr(tag_wr);
            end
            if (resp_arrive && (drop_cnt != '0))
               drop_cnt <= drop_cnt - cnt_t'(1);
            if (resp_keep)
               tag_rd <= next_ptr(tag_rd);
            if (push)
               wr_ptr <= next_ptr(wr_ptr);
            if (pop)
               rd_ptr <= next_ptr(rd_ptr);
            count <= count + cnt_t'(push) - cnt_t'(pop);
         end
      end
   end

   // Storage arrays carry no reset; validity is tracked by the pointers and counters above.
   always_ff @(posedge clk) begin
      if (req_fire)
         tag_mem[tag_wr] <= pc;
      if (push) begin
         data_mem[wr_ptr] <= bus.imem_resp_data;
         pc_mem[wr_ptr]   <= tag_mem[tag_rd];
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model, stream-level reference model, directed and random phases.
module tb_fetch_unit;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 2;
`ifdef FETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   fetch_unit_if bus();
   fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

   typedef struct {
      logic [31:0] addr;
      int unsigned due;
   } mreq_t;

   typedef struct {
      logic [31:0] rpc;
      logic [31:0] exp_a0;
      logic [31:0] exp_a1;
      logic [31:0] exp_pc0;
   } vec_t;

   mreq_t       mem_q[$];
   logic [31:0] hs_log[$];
   logic [31:0] pop_log[$];
   vec_t        vecs[5];
   int unsigned cyc, mem_lat, last_due;
   logic        d_ready, d_if_ready, d_redirect, inject_junk;
   logic [31:0] d_redirect_pc;
   logic [31:0] exp_req, exp_pc;
   int          stale, buf_n;
   logic        s_req_valid, s_if_valid, s_hs, s_pop;
   logic [31:0] s_addr, s_instr, s_pc;
   int          n_chk, n_pass;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
      if (i < q.size()) return q[i];
      return 32'hDEAD_DEAD;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Drive one cycle's inputs, sample outputs before the next rising edge, advance the model.
   task automatic cycle_body();
      logic        resp, kept, bypassed, fifo_pop;
      logic [31:0] raddr;
      int          pend;
      int unsigned due;
      bus.imem_req_ready = d_ready;
      bus.if_ready       = d_if_ready;
      bus.redirect       = d_redirect;
      bus.redirect_pc    = d_redirect_pc;
      resp  = 1'b0;
      raddr = '0;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         resp  = 1'b1;
         raddr = mem_q[0].addr;
         void'(mem_q.pop_front());
      end
      if (resp) begin
         bus.imem_resp_valid = 1'b1;
         bus.imem_resp_data  = mem_data(raddr);
      end else if (inject_junk) begin
         bus.imem_resp_valid = 1'b1;
         bus.imem_resp_data  = 32'hDEAD_BEEF;
      end else begin
         bus.imem_resp_valid = 1'b0;
         bus.imem_resp_data  = '0;
      end
      #1;
      s_req_valid = bus.imem_req_valid;
      s_addr      = bus.imem_req_addr;
      s_if_valid  = bus.if_valid;
      s_instr     = bus.if_instr;
      s_pc        = bus.if_pc;
      s_hs        = s_req_valid & d_ready;
      s_pop       = s_if_valid & d_if_ready & !d_redirect;
      pend = mem_q.size() + (resp ? 1 : 0);
      kept = resp && !d_redirect && (stale == 0);
      check("req_valid", 32'(s_req_valid), 32'(!d_redirect && (pend + buf_n < DEPTH)));
      check("if_valid", 32'(s_if_valid), 32'((buf_n > 0) || (BYP && kept)));
      if (s_hs) begin
         check("req_addr", s_addr, exp_req);
         hs_log.push_back(s_addr);
         due = cyc + mem_lat;
         if (due < last_due) due = last_due;
         last_due = due;
         mem_q.push_back('{addr: s_addr, due: due});
         exp_req = exp_req + 32'd4;
      end
      if (s_pop) begin
         check("if_pc", s_pc, exp_pc);
         check("if_instr", s_instr, mem_data(exp_pc));
         pop_log.push_back(s_pc);
         exp_pc = exp_pc + 32'd4;
      end
      if (d_redirect) begin
         stale   = mem_q.size();
         buf_n   = 0;
         exp_req = d_redirect_pc & 32'hFFFF_FFFC;
         exp_pc  = d_redirect_pc & 32'hFFFF_FFFC;
      end else begin
         if (resp && stale > 0) stale--;
         bypassed = BYP && kept && (buf_n == 0) && d_if_ready;
         fifo_pop = s_pop && (buf_n > 0);
         buf_n    = buf_n + ((kept && !bypassed) ? 1 : 0) - (fifo_pop ? 1 : 0);
      end
      cyc++;
   endtask

   task automatic step();
      @(negedge clk);
      cycle_body();
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst_if_valid", 32'(bus.if_valid), 32'd0);
      check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      bus.imem_resp_valid = 1'b0;
      mem_q.delete();
      hs_log.delete();
      pop_log.delete();
      stale    = 0;
      buf_n    = 0;
      last_due = 0;
      exp_req  = RESET_PC;
      exp_pc   = RESET_PC;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      cycle_body();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      n_chk = 0; n_pass = 0; cyc = 0; mem_lat = 1; last_due = 0;
      stale = 0; buf_n = 0; exp_req = RESET_PC; exp_pc = RESET_PC;
      d_ready = 1'b1; d_if_ready = 1'b1; d_redirect = 1'b0; d_redirect_pc = '0; inject_junk = 1'b0;
      bus.imem_req_ready = 1'b0; bus.imem_resp_valid = 1'b0; bus.imem_resp_data = '0;
      bus.redirect = 1'b0; bus.redirect_pc = '0; bus.if_ready = 1'b0;

      vecs[0] = '{rpc: 32'h0000_0103, exp_a0: 32'h0000_0100, exp_a1: 32'h0000_0104, exp_pc0: 32'h0000_0100};
      vecs[1] = '{rpc: 32'hFFFF_FFFC, exp_a0: 32'hFFFF_FFFC, exp_a1: 32'h0000_0000, exp_pc0: 32'hFFFF_FFFC};
      vecs[2] = '{rpc: 32'hFFFF_FFFF, exp_a0: 32'hFFFF_FFFC, exp_a1: 32'h0000_0000, exp_pc0: 32'hFFFF_FFFC};
      vecs[3] = '{rpc: 32'h0000_1002, exp_a0: 32'h0000_1000, exp_a1: 32'h0000_1004, exp_pc0: 32'h0000_1000};
      vecs[4] = '{rpc: 32'h7FFF_FFFD, exp_a0: 32'h7FFF_FFFC, exp_a1: 32'h8000_0000, exp_pc0: 32'h7FFF_FFFC};

      // Reset release, single-cycle memory, free-running decode.
      do_reset();
      repeat (8) step();
      check("seq_a0", q_at(hs_log, 0), 32'h0);
      check("seq_a1", q_at(hs_log, 1), 32'h4);
      check("seq_a2", q_at(hs_log, 2), 32'h8);
      check("seq_pc0", q_at(pop_log, 0), 32'h0);
      check("seq_pc1", q_at(pop_log, 1), 32'h4);
      check("seq_pc2", q_at(pop_log, 2), 32'h8);

      // Decode stalled for five cycles.
      d_if_ready = 1'b0;
      do_reset();
      repeat (4) step();
      check("stall_req_count", 32'(hs_log.size()), 32'd2);
      check("stall_a1", q_at(hs_log, 1), 32'h4);
      check("stall_req_valid", 32'(s_req_valid), 32'd0);
      check("stall_head_valid", 32'(s_if_valid), 32'd1);
      check("stall_head_pc", s_pc, 32'h0);
      d_if_ready = 1'b1;
      step();
      check("stall_pop_pc", q_at(pop_log, 0), 32'h0);
      step();
      check("stall_req_resume", 32'(s_req_valid), 32'd1);

      // Redirect with two requests outstanding.
      mem_lat = 3;
      do_reset();
      step();
      d_redirect = 1'b1; d_redirect_pc = 32'h0000_0103;
      step();
      check("redir_req_valid", 32'(s_req_valid), 32'd0);
      d_redirect = 1'b0;
      hs_log.delete(); pop_log.delete();
      repeat (12) step();
      check("redir_a0", q_at(hs_log, 0), 32'h0000_0100);
      check("redir_pc0", q_at(pop_log, 0), 32'h0000_0100);
      check("redir_pc1", q_at(pop_log, 1), 32'h0000_0104);

      // Memory not ready: address must hold.
      mem_lat = 1;
      do_reset();
      for (int i = 0; i < 20 && exp_req != 32'h8; i++) step();
      d_ready = 1'b0;
      repeat (3) begin
         step();
         check("hold_addr", s_addr, 32'h8);
      end
      d_ready = 1'b1;
      hs_log.delete();
      for (int i = 0; i < 10 && hs_log.size() == 0; i++) step();
      check("hold_hs_addr", q_at(hs_log, 0), 32'h8);
      step();
      check("hold_next_addr", s_addr, 32'hC);

      // Redirect target table, including wrap past the top of the address space.
      mem_lat = 2;
      for (int v = 0; v < 5; v++) begin
         d_redirect = 1'b1; d_redirect_pc = vecs[v].rpc;
         step();
         d_redirect = 1'b0;
         hs_log.delete(); pop_log.delete();
         for (int i = 0; i < 40 && (hs_log.size() < 2 || pop_log.size() < 1); i++) step();
         check("vec_a0", q_at(hs_log, 0), vecs[v].exp_a0);
         check("vec_a1", q_at(hs_log, 1), vecs[v].exp_a1);
         check("vec_pc0", q_at(pop_log, 0), vecs[v].exp_pc0);
      end

      // Reset with the FIFO full, then a stray response right after release.
      mem_lat = 1; d_if_ready = 1'b0;
      do_reset();
      repeat (6) step();
      check("full_head_valid", 32'(s_if_valid), 32'd1);
      d_if_ready = 1'b1; inject_junk = 1'b1;
      do_reset();
      inject_junk = 1'b0;
      check("post_rst_addr", s_addr, RESET_PC);
      check("post_rst_req_valid", 32'(s_req_valid), 32'd1);
      step();
      check("resp_latency_c1", 32'(s_if_valid), 32'(BYP));
      step();
      check("resp_latency_c2", 32'(s_if_valid), 32'd1);

      // Random traffic against the stream model.
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) mem_lat = $urandom_range(1, 3);
         d_ready       = ($urandom_range(0, 3) != 0);
         d_if_ready    = ($urandom_range(0, 9) < 7);
         d_redirect    = ($urandom_range(0, 39) == 0);
         d_redirect_pc = $urandom;
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
